// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared constants and encodings for the sprite ROM path: sprite geometry,
// number of animation banks, transparent colour key, the player state
// encoding that selects the animation bank, the response class carried
// down the tag pipeline, and the round-robin pointer states.
package sprite_pkg;

  localparam int         SPRITE_W     = 150;
  localparam int         SPRITE_H     = 157;
  localparam int         SPRITE_WORDS = SPRITE_W * SPRITE_H;
  localparam int         NUM_BANKS    = 6;
  localparam logic [7:0] TRANSP_KEY   = 8'hE3;

  // Player state doubles as the animation bank index.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_FWD  = 3'd1,
    MOVE_BWD  = 3'd2,
    ATK_START = 3'd3,
    ATK_END   = 3'd4,
    ATK_PULL  = 3'd5
  } player_state_e;

  typedef enum logic [1:0] {
    CLS_ROM     = 2'd0,
    CLS_OOR     = 2'd1,
    CLS_DEFAULT = 2'd2
  } rsp_class_e;

  typedef enum logic {
    LAST_P1 = 1'b0,
    LAST_P2 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. Grants are combinational from the current
// requests and a one-bit pointer naming the last granted requester.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointer -> LAST_P2)
//   req0, req1   : requests from player 1 / player 2
//   gnt0, gnt1   : one-hot (or zero) grants, forced low during reset
module rr_arbiter2
  import sprite_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  rr_ptr_e ptr;
  rr_ptr_e ptr_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) ptr <= LAST_P2;
    else     ptr <= ptr_next;
  end

  // Next-state: pointer follows the grant, holds when idle
  always_comb begin
    ptr_next = ptr;
    if (gnt0)      ptr_next = LAST_P1;
    else if (gnt1) ptr_next = LAST_P2;
  end

  // Outputs: under contention the requester not named by the pointer wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || ptr == LAST_P2)) gnt0 = 1'b1;
      else if (req1)                         gnt1 = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one synchronous sprite ROM (all animation banks) between two player
// renderers. Accepted requests are classified (ROM / out-of-range / default
// bank), ROM requests drive a registered read, and every accept returns one
// response tagged with the requester ID exactly three cycles later.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   req0/req1               : pixel requests (hold fields until granted)
//   bank0/1, dx0/1, dy0/1   : animation bank and sprite-relative coordinates
//   gnt0/gnt1               : combinational grants (accept = req & gnt)
//   rom_rd, rom_addr        : registered ROM read strobe / address
//   rom_q                   : ROM data, valid the cycle after rom_addr sampled
//   rsp_valid/id/data/visible : one-cycle response, in accept order
module sprite_rom_arbiter #(
  parameter int         SPRITE_W   = sprite_pkg::SPRITE_W,
  parameter int         SPRITE_H   = sprite_pkg::SPRITE_H,
  parameter int         NUM_BANKS  = sprite_pkg::NUM_BANKS,
  parameter int         ADDR_W     = 18,
  parameter logic [7:0] TRANSP_KEY = sprite_pkg::TRANSP_KEY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [2:0]        bank0,
  input  logic [2:0]        bank1,
  input  logic [9:0]        dx0,
  input  logic [9:0]        dy0,
  input  logic [9:0]        dx1,
  input  logic [9:0]        dy1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [7:0]        rsp_data,
  output logic              rsp_visible
);

  import sprite_pkg::*;

  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(SPRITE_W);

  function automatic rsp_class_e classify(input logic [2:0] bank,
                                          input logic [9:0] dx,
                                          input logic [9:0] dy);
    if (int'(bank) >= NUM_BANKS) return CLS_DEFAULT;
    if (int'(dx) >= SPRITE_W || int'(dy) >= SPRITE_H) return CLS_OOR;
    return CLS_ROM;
  endfunction

  // Every operand is widened to ADDR_W first so no partial product truncates.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [2:0] bank,
                                                   input logic [9:0] dx,
                                                   input logic [9:0] dy);
    return ADDR_W'(bank) * WORDS_A + ADDR_W'(dy) * WIDTH_A + ADDR_W'(dx);
  endfunction

  logic       accept;
  logic [2:0] sel_bank;
  logic [9:0] sel_dx;
  logic [9:0] sel_dy;
  rsp_class_e sel_cls;

  logic       vld_p0, vld_p1;
  logic       id_p0, id_p1;
  rsp_class_e cls_p0, cls_p1;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign accept   = gnt0 | gnt1;
  assign sel_bank = gnt1 ? bank1 : bank0;
  assign sel_dx   = gnt1 ? dx1   : dx0;
  assign sel_dy   = gnt1 ? dy1   : dy0;
  assign sel_cls  = classify(sel_bank, sel_dx, sel_dy);

  // ---- Stage p0: accept -> ROM read issue, tag captured ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
    end else begin
      vld_p0 <= accept;
      rom_rd <= accept && (sel_cls == CLS_ROM);
      // Non-ROM classes leave the address bus untouched.
      if (accept && (sel_cls == CLS_ROM))
        rom_addr <= pixel_addr(sel_bank, sel_dx, sel_dy);
    end
  end

  always_ff @(posedge clk) begin
    id_p0  <= gnt1;
    cls_p0 <= sel_cls;
  end

  // ---- Stage p1: ROM access cycle, tag waits alongside ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    id_p1  <= id_p0;
    cls_p1 <= cls_p0;
  end

  // ---- Stage p2: rom_q is valid now; build response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_visible <= 1'b0;
    end else begin
      rsp_valid <= vld_p1;
      if (vld_p1) begin
        rsp_id <= id_p1;
        unique case (cls_p1)
          CLS_ROM: begin
            rsp_data    <= rom_q;
            rsp_visible <= (rom_q != TRANSP_KEY);
          end
          CLS_OOR: begin
            rsp_data    <= 8'h00;
            rsp_visible <= 1'b0;
          end
          default: begin
            rsp_data    <= 8'hFF;
            rsp_visible <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
